// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - op encoding shared by the program counter and its bench
package pc_pkg;
  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_HOLD = 3'b000;
  localparam logic [OP_W-1:0] OP_INC  = 3'b001;
  localparam logic [OP_W-1:0] OP_JMP  = 3'b010;
  localparam logic [OP_W-1:0] OP_BRC  = 3'b011;
  localparam logic [OP_W-1:0] OP_CALL = 3'b100;
  localparam logic [OP_W-1:0] OP_RET  = 3'b101;
  localparam logic [OP_W-1:0] OP_SKIP = 3'b110;
endpackage

// File: rtl/pc_ret_stack.sv
// rtl/pc_ret_stack.sv - LIFO return-address stack; push when full and pop when empty are ignored
module pc_ret_stack #(
  parameter int PC_W      = 4,
  parameter int STK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] data,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);
  localparam int CW = $clog2(STK_DEPTH + 1);
  localparam int IW = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

  logic [PC_W-1:0] mem [STK_DEPTH];
  logic [CW-1:0]   count;
  logic [CW-1:0]   top_idx;

  assign full    = (count == CW'(STK_DEPTH));
  assign empty   = (count == '0);
  assign top_idx = count - CW'(1);
  assign top     = mem[top_idx[IW-1:0]];

  // Entries need no reset: only slots below count are ever read meaningfully.
  always_ff @(posedge clk) begin
    if (push && !full) mem[count[IW-1:0]] <= data;
  end

  always_ff @(posedge clk) begin
    if (rst)                  count <= '0;
    else if (push && !full)   count <= count + CW'(1);
    else if (pop && !empty)   count <= count - CW'(1);
  end
endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program counter with relative branch and return-address stack
// Optional SKIP op (110) enabled by defining PC_SKIP_EN.
module pc_seq
  import pc_pkg::*;
#(
  parameter int              PC_W      = 4,
  parameter int              STK_DEPTH = 4,
  parameter logic [PC_W-1:0] RST_VEC   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [OP_W-1:0] op,
  input  logic            cond,
  input  logic [PC_W-1:0] TARGET,
  input  logic [PC_W-1:0] OFFSET,
  output logic [PC_W-1:0] PC_CURR,
  output logic            stk_full,
  output logic            stk_empty,
  output logic            stk_err
);
  logic [PC_W-1:0] pc, pc_next, pc_inc, stk_top;
  logic            push, pop, err_set;

  assign pc_inc  = pc + PC_W'(1);
  assign PC_CURR = pc;

  always_comb begin
    pc_next = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    case (op)
      OP_HOLD: pc_next = pc;
      OP_JMP:  pc_next = TARGET;
      // Two's-complement add is the same bit operation as unsigned mod 2^PC_W.
      OP_BRC:  pc_next = cond ? (pc + OFFSET) : pc_inc;
      OP_CALL: begin
        if (stk_full) err_set = 1'b1;
        else begin
          push    = 1'b1;
          pc_next = TARGET;
        end
      end
      OP_RET: begin
        if (stk_empty) err_set = 1'b1;
        else begin
          pop     = 1'b1;
          pc_next = stk_top;
        end
      end
`ifdef PC_SKIP_EN
      OP_SKIP: pc_next = cond ? (pc + PC_W'(2)) : pc_inc;
`endif
      default: pc_next = pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RST_VEC;
      stk_err <= 1'b0;
    end else if (en) begin
      pc <= pc_next;
      if (err_set) stk_err <= 1'b1;
    end
  end

  pc_ret_stack #(
    .PC_W      (PC_W),
    .STK_DEPTH (STK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push && en),
    .pop   (pop && en),
    .data  (pc_inc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );
endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - scoreboard bench for pc_seq against a queue-based reference model
module tb_pc_seq;
  localparam int PC_W  = 4;
  localparam int DEPTH = 4;
  localparam int RV    = 3;
  localparam int MASK  = (1 << PC_W) - 1;

  typedef struct {
    int pc;
    bit full;
    bit empty;
    bit err;
    int idx;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst, en, cond;
  logic [2:0]      op;
  logic [PC_W-1:0] target, offset, pc_curr;
  logic            stk_full, stk_empty, stk_err;

  pc_seq #(
    .PC_W      (PC_W),
    .STK_DEPTH (DEPTH),
    .RST_VEC   (PC_W'(RV))
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .op        (op),
    .cond      (cond),
    .TARGET    (target),
    .OFFSET    (offset),
    .PC_CURR   (pc_curr),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .stk_err   (stk_err)
  );

  always #5 clk = ~clk;

  int   m_pc;
  int   m_stk[$];
  bit   m_err;
  exp_t sb[$];
  exp_t cur;
  int   vectors = 0;
  int   miscompares = 0;
  int   issued = 0;

  task automatic apply(input bit r, input bit e, input int o, input bit c,
                       input int t, input int f);
    int off;
    rst    = r;
    en     = e;
    op     = o[2:0];
    cond   = c;
    target = t[PC_W-1:0];
    offset = f[PC_W-1:0];
    off = f & MASK;
    if (off >= (1 << (PC_W - 1))) off = off - (1 << PC_W);
    if (r) begin
      m_pc = RV;
      m_stk.delete();
      m_err = 1'b0;
    end else if (e) begin
      case (o & 7)
        0: ;
        2: m_pc = t & MASK;
        3: m_pc = c ? ((m_pc + off) & MASK) : ((m_pc + 1) & MASK);
        4: begin
          if (m_stk.size() == DEPTH) begin
            m_err = 1'b1;
            m_pc  = (m_pc + 1) & MASK;
          end else begin
            m_stk.push_back((m_pc + 1) & MASK);
            m_pc = t & MASK;
          end
        end
        5: begin
          if (m_stk.size() == 0) begin
            m_err = 1'b1;
            m_pc  = (m_pc + 1) & MASK;
          end else m_pc = m_stk.pop_back();
        end
`ifdef PC_SKIP_EN
        6: m_pc = (m_pc + (c ? 2 : 1)) & MASK;
`endif
        default: m_pc = (m_pc + 1) & MASK;
      endcase
    end
    @(posedge clk);
    #1;
    sb.push_back('{m_pc, m_stk.size() == DEPTH, m_stk.size() == 0, m_err, issued});
    issued++;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      vectors++;
      if (int'(pc_curr) != cur.pc || stk_full !== cur.full ||
          stk_empty !== cur.empty || stk_err !== cur.err) begin
        miscompares++;
        $display("FAIL vec%0d: got pc=%0d full=%b empty=%b err=%b, expected pc=%0d full=%b empty=%b err=%b",
                 cur.idx, pc_curr, stk_full, stk_empty, stk_err,
                 cur.pc, cur.full, cur.empty, cur.err);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; op = 3'd0; cond = 1'b0; target = '0; offset = '0;
    m_pc = RV; m_err = 1'b0;

    apply(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) apply(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++)  apply(0, 0, 2, 0, 9, 0);
    apply(0, 1, 2, 0, 9, 0);

    apply(0, 1, 2, 0, 10, 0);
    apply(0, 1, 3, 1, 0, 13);
    apply(0, 1, 2, 0, 10, 0);
    apply(0, 1, 3, 0, 0, 13);
    apply(0, 1, 2, 0, 14, 0);
    apply(0, 1, 3, 1, 0, 3);

    apply(0, 1, 2, 0, 2, 0);
    apply(0, 1, 4, 0, 8, 0);
    apply(0, 1, 4, 0, 12, 0);
    apply(0, 1, 5, 0, 0, 0);
    apply(0, 1, 5, 0, 0, 0);

    for (int i = 0; i < 4; i++) apply(0, 1, 4, 0, 1 + i, 0);
    apply(0, 1, 2, 0, 6, 0);
    apply(0, 1, 4, 0, 5, 0);
    for (int i = 0; i < 4; i++) apply(0, 1, 5, 0, 0, 0);
    apply(0, 1, 5, 0, 0, 0);
    apply(0, 0, 5, 0, 0, 0);

    apply(0, 1, 2, 0, 15, 0);
    apply(0, 1, 6, 1, 0, 0);
    apply(0, 1, 2, 0, 4, 0);
    apply(0, 1, 6, 0, 0, 0);
    apply(0, 1, 2, 0, 4, 0);
    apply(0, 1, 6, 1, 0, 0);
    apply(0, 1, 7, 1, 0, 0);

    apply(0, 1, 4, 0, 11, 0);
    apply(1, 1, 4, 0, 7, 0);

    for (int i = 0; i < 400; i++)
      apply($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 85,
            int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)));

    repeat (3) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
